// File: rtl/serial_shifter32.sv
// serial_shifter32: multi-cycle shifter that matches the combinational
// 32-bit barrel shifter, one single-bit shift per clock.
// aluc: 00 arithmetic right, 01 logical right, 10/11 left (zero fill).
// Handshake: start is taken only in IDLE; busy covers SHIFT and DONE;
// done is a one-cycle pulse in DONE, with c already holding the result.
module serial_shifter32 #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [SHW-1:0]   b,
    input  logic [1:0]       aluc,
    output logic [WIDTH-1:0] c,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    localparam logic [SHW-1:0] CNT_ZERO = {SHW{1'b0}};
    localparam logic [SHW-1:0] CNT_ONE  = SHW'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q,  data_d;
    logic [SHW-1:0]   cnt_q,   cnt_d;
    logic [1:0]       type_q,  type_d;
    logic [WIDTH-1:0] c_q,     c_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;
    logic [WIDTH-1:0] shifted_s;

    // One-position shift; both left encodings are the same operation.
    function automatic logic [WIDTH-1:0] shift1(input logic [WIDTH-1:0] d,
                                                input logic [1:0]       t);
        logic [WIDTH-1:0] r;
        case (t)
            2'b00:   r = {d[WIDTH-1], d[WIDTH-1:1]};
            2'b01:   r = {1'b0, d[WIDTH-1:1]};
            default: r = {d[WIDTH-2:0], 1'b0};
        endcase
        return r;
    endfunction

    assign shifted_s = shift1(data_q, type_q);

    // Next-state, datapath and output decode for the IDLE/SHIFT/DONE sequencer.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        type_d  = type_q;
        c_d     = c_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    data_d = a;
                    cnt_d  = b;
                    type_d = aluc;
                    if (b == CNT_ZERO) begin
                        // Nothing to shift: publish the operand directly.
                        state_d = ST_DONE;
                        c_d     = a;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                data_d = shifted_s;
                cnt_d  = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    // Last shift: result register is loaded on entry to DONE.
                    state_d = ST_DONE;
                    c_d     = shifted_s;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // State, datapath and registered outputs; reset aborts any operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            data_q  <= {WIDTH{1'b0}};
            cnt_q   <= CNT_ZERO;
            type_q  <= 2'b00;
            c_q     <= {WIDTH{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            type_q  <= type_d;
            c_q     <= c_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign c    = c_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_serial_shifter32.sv
// Self-checking bench for serial_shifter32: directed vectors plus random
// operations compared with a plain-arithmetic shift model.
module tb_serial_shifter32;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] a;
    logic [4:0]  b;
    logic [1:0]  aluc;
    logic [31:0] c;
    logic        busy;
    logic        done;

    int errors = 0;
    int checks = 0;

    serial_shifter32 #(.WIDTH(32), .SHW(5)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .aluc  (aluc),
        .c     (c),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    // Reference: whole shift in one step using the language shift operators.
    function automatic logic [31:0] ref_shift(input logic [31:0] x, input int n,
                                              input logic [1:0] t);
        case (t)
            2'b00:   return 32'($signed(x) >>> n);
            2'b01:   return x >> n;
            default: return x << n;
        endcase
    endfunction

    // Issue one operation (called at a negedge) and observe it to completion.
    // lat: cycles from the accepting edge to the done cycle, inclusive (b+1).
    task automatic do_op(input logic [31:0] av, input logic [4:0] bv,
                         input logic [1:0] tv, input bit hold,
                         output int lat, output int bcyc,
                         output logic [31:0] cres, output bit extra,
                         output bit c_early);
        logic [31:0] c0;
        c0 = c;
        start = 1'b1; a = av; b = bv; aluc = tv;
        lat = -1; bcyc = 0; extra = 1'b0; c_early = 1'b0; cres = 32'h0;
        @(negedge clk);
        if (!hold) start = 1'b0;
        for (int k = 0; k < 80; k++) begin
            if (busy) bcyc++;
            if (done) begin
                if (lat < 0) begin
                    lat = k + 1;
                    cres = c;
                end else begin
                    extra = 1'b1;
                end
            end else if (lat < 0 && c !== c0) begin
                c_early = 1'b1;
            end
            if (!busy && lat >= 0) break;
            @(negedge clk);
            a = $urandom; b = 5'($urandom); aluc = 2'($urandom);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a = 32'h0; b = 5'd0; aluc = 2'b00;
        repeat (2) @(negedge clk);
        checks++; if (c !== 32'h0) begin errors++; $display("FAIL reset_c: got %h want 00000000", c); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_aluc_modes();
        logic [31:0] exp_tab [4];
        int lat, bc; logic [31:0] cr; bit ex, ce;
        exp_tab[0] = 32'hFF555555; exp_tab[1] = 32'h01555555;
        exp_tab[2] = 32'h55555500; exp_tab[3] = 32'h55555500;
        for (int i = 0; i < 4; i++) begin
            do_op(32'hAAAAAAAA, 5'd7, 2'(i), 1'b0, lat, bc, cr, ex, ce);
            checks++; if (cr !== exp_tab[i]) begin errors++; $display("FAIL mode%0d_c: got %h want %h", i, cr, exp_tab[i]); end
            checks++; if (lat != 8) begin errors++; $display("FAIL mode%0d_latency: got %0d want 8", i, lat); end
            checks++; if (bc != 8) begin errors++; $display("FAIL mode%0d_busy_cycles: got %0d want 8", i, bc); end
            checks++; if (ex || ce) begin errors++; $display("FAIL mode%0d_pulse: extra_done=%0d c_changed_early=%0d want 0 0", i, ex, ce); end
        end
    endtask

    task automatic test_zero_shift();
        int lat, bc; logic [31:0] cr; bit ex, ce;
        do_op(32'h12345678, 5'd0, 2'b01, 1'b0, lat, bc, cr, ex, ce);
        checks++; if (cr !== 32'h12345678) begin errors++; $display("FAIL zero_c: got %h want 12345678", cr); end
        checks++; if (lat != 1) begin errors++; $display("FAIL zero_latency: got %0d want 1", lat); end
        checks++; if (bc != 1) begin errors++; $display("FAIL zero_busy_cycles: got %0d want 1", bc); end
        checks++; if (ex || ce) begin errors++; $display("FAIL zero_pulse: extra_done=%0d c_changed_early=%0d want 0 0", ex, ce); end
    endtask

    task automatic test_max_shift();
        logic [31:0] av [3];
        logic [1:0]  tv [3];
        logic [31:0] ev [3];
        int lat, bc; logic [31:0] cr; bit ex, ce;
        av[0] = 32'h80000000; tv[0] = 2'b00; ev[0] = 32'hFFFFFFFF;
        av[1] = 32'h80000000; tv[1] = 2'b01; ev[1] = 32'h00000001;
        av[2] = 32'h00000001; tv[2] = 2'b11; ev[2] = 32'h80000000;
        for (int i = 0; i < 3; i++) begin
            do_op(av[i], 5'd31, tv[i], 1'b0, lat, bc, cr, ex, ce);
            checks++; if (cr !== ev[i]) begin errors++; $display("FAIL max%0d_c: got %h want %h", i, cr, ev[i]); end
            checks++; if (lat != 32) begin errors++; $display("FAIL max%0d_latency: got %0d want 32", i, lat); end
            checks++; if (bc != 32) begin errors++; $display("FAIL max%0d_busy_cycles: got %0d want 32", i, bc); end
            checks++; if (ex || ce) begin errors++; $display("FAIL max%0d_pulse: extra_done=%0d c_changed_early=%0d want 0 0", i, ex, ce); end
        end
    endtask

    task automatic test_random();
        logic [31:0] av, ev; logic [4:0] bv; logic [1:0] tv;
        int lat, bc; logic [31:0] cr; bit ex, ce;
        for (int i = 0; i < 24; i++) begin
            av = $urandom; bv = 5'($urandom); tv = 2'($urandom);
            ev = ref_shift(av, int'(bv), tv);
            do_op(av, bv, tv, 1'b0, lat, bc, cr, ex, ce);
            checks++; if (cr !== ev) begin errors++; $display("FAIL rand%0d_c: a=%h b=%0d aluc=%b got %h want %h", i, av, bv, tv, cr, ev); end
            checks++; if (lat != int'(bv) + 1 || ex || ce) begin errors++; $display("FAIL rand%0d_timing: latency=%0d want %0d extra_done=%0d c_changed_early=%0d", i, lat, int'(bv) + 1, ex, ce); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a1, a2;
        int lat, bc; logic [31:0] cr; bit ex, ce;
        a1 = $urandom; a2 = $urandom;
        // start stays high for the whole first operation while inputs churn
        do_op(a1, 5'd9, 2'b00, 1'b1, lat, bc, cr, ex, ce);
        checks++; if (cr !== ref_shift(a1, 9, 2'b00)) begin errors++; $display("FAIL b2b_first_c: got %h want %h", cr, ref_shift(a1, 9, 2'b00)); end
        checks++; if (lat != 10) begin errors++; $display("FAIL b2b_first_latency: got %0d want 10", lat); end
        checks++; if (bc != 10 || ex) begin errors++; $display("FAIL b2b_first_busy: busy_cycles=%0d extra_done=%0d want 10 0", bc, ex); end
        // next request issued in the first IDLE cycle after DONE
        do_op(a2, 5'd3, 2'b10, 1'b0, lat, bc, cr, ex, ce);
        checks++; if (cr !== ref_shift(a2, 3, 2'b10)) begin errors++; $display("FAIL b2b_second_c: got %h want %h", cr, ref_shift(a2, 3, 2'b10)); end
        checks++; if (lat != 4 || bc != 4) begin errors++; $display("FAIL b2b_second_timing: latency=%0d busy_cycles=%0d want 4 4", lat, bc); end
    endtask

    task automatic test_abort();
        int lat, bc; logic [31:0] cr; bit ex, ce;
        bit saw_done;
        do_op(32'hDEADBEEF, 5'd4, 2'b01, 1'b0, lat, bc, cr, ex, ce);
        checks++; if (cr !== 32'h0DEADBEE) begin errors++; $display("FAIL abort_setup_c: got %h want 0deadbee", cr); end
        start = 1'b1; a = 32'hCAFEF00D; b = 5'd20; aluc = 2'b11;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if (c !== 32'h0) begin errors++; $display("FAIL abort_c: got %h want 00000000", c); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL abort_flags: busy=%b done=%b want 0 0", busy, done); end
        #1 rst = 1'b0;
        saw_done = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        checks++; if (saw_done || c !== 32'h0) begin errors++; $display("FAIL abort_quiet: activity=%0d c=%h want 0 00000000", saw_done, c); end
        do_op(32'h0000F00F, 5'd5, 2'b11, 1'b0, lat, bc, cr, ex, ce);
        checks++; if (cr !== 32'h001E01E0 || lat != 6) begin errors++; $display("FAIL abort_fresh: c=%h latency=%0d want 001e01e0 6", cr, lat); end
    endtask

    initial begin
        test_reset();
        test_aluc_modes();
        test_zero_shift();
        test_max_shift();
        test_random();
        test_back_to_back();
        test_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
